// File: rtl/core_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry and
// the loader state encoding.
package core_pkg;

  localparam int IMEM_DEPTH  = 4096;
  localparam int LOADER_BASE = 4068;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects UART bytes little-endian into a 32-bit word; used for both the
// header count and the instruction words.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        last
);

  logic [1:0] count;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign word_next = {byte_data, word[31:8]};
  assign last      = shift && (count == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift) begin
      word  <= word_next;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program from a UART byte stream into instruction
// memory, one 32-bit word per write handshake.
module imem_loader
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [11:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [12:0] words_loaded
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  loader_state_t state, state_next;
  logic [12:0]   word_count;
  logic          shift, clear, last;
  logic [31:0]   word, word_next;

  assign shift = rx_valid && rx_ready;

  word_assembler u_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift     (shift),
    .byte_data (rx_data),
    .word      (word),
    .word_next (word_next),
    .last      (last)
  );

  // The assembler register already holds the finished word while in WRITE.
  assign wr_data = word;
  assign wr_addr = words_loaded[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    wr_valid   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, ERR: begin
        busy = 1'b0;
        err  = (state == ERR);
        if (start) begin
          clear      = 1'b1;
          state_next = HDR;
        end
      end
      HDR: begin
        rx_ready = 1'b1;
        // Counts that would reach the resident loader's words are rejected.
        if (last) begin
          if (word_next == 32'd0)                 state_next = DONE;
          else if (word_next > 32'(LOADER_BASE))  state_next = ERR;
          else                                    state_next = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (last) state_next = WRITE;
      end
      WRITE: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          if (words_loaded + 13'd1 == word_count) state_next = DONE;
          else                                    state_next = DATA;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_loaded <= '0;
      word_count   <= '0;
    end else begin
      if (clear) words_loaded <= '0;
      else if (state == WRITE && wr_ready) words_loaded <= words_loaded + 13'd1;
      if (state == HDR && last) word_count <= word_next[12:0];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a random byte source and write sink
// driven against a queue-based model of the expected memory writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid, wr_ready;
  logic [7:0]  rx_data;
  logic        rx_ready, wr_valid, busy, done, err;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [12:0] words_loaded;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [7:0]  byte_q[$];
  logic [31:0] prog[$];
  logic [31:0] exp_data_q[$];
  int          exp_addr_q[$];

  int rx_pct = 100, wr_pct = 100, stall_left = 0;
  int tick_no = 0, bytes_fired = 0, writes_seen = 0, done_cnt = 0;
  int expect_wv_tick = -1, hdr_tick = -1, done_tick = -1, last_addr = -1;
  logic err_seen = 1'b0, prev_done = 1'b0, stalled = 1'b0, finished;
  logic [11:0] held_addr;
  logic [31:0] held_data;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rx_ready"}, 32'(rx_ready), 0);
    check_output({tag, "_wr_valid"}, 32'(wr_valid), 0);
    check_output({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_output({tag, "_wr_data"}, wr_data, 0);
    check_output({tag, "_busy"}, 32'(busy), 0);
    check_output({tag, "_done"}, 32'(done), 0);
    check_output({tag, "_err"}, 32'(err), 0);
    check_output({tag, "_words_loaded"}, 32'(words_loaded), 0);
  endtask

  // One clock cycle: drive at the falling edge, observe, then commit at the rising edge.
  task automatic apply_stimulus();
    logic bf, wf;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = (byte_q.size() > 0) && ($urandom_range(99) < rx_pct);
    rx_data  = rx_valid ? byte_q[0] : 8'($urandom);
    if (wr_valid && stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else begin
      wr_ready = ($urandom_range(99) < wr_pct);
    end
    #1;
    tick_no++;
    if (tick_no == expect_wv_tick) check_output("wr_valid_latency", 32'(wr_valid), 1);
    if (stalled) begin
      check_output("stall_wr_valid", 32'(wr_valid), 1);
      check_output("stall_wr_addr", 32'(wr_addr), 32'(held_addr));
      check_output("stall_wr_data", wr_data, held_data);
      check_output("stall_rx_ready", 32'(rx_ready), 0);
    end
    stalled   = wr_valid && !wr_ready;
    held_addr = wr_addr;
    held_data = wr_data;
    if (done) begin
      check_output("done_one_cycle", 32'(prev_done), 0);
      done_cnt++;
      done_tick = tick_no;
    end
    prev_done = done;
    if (err) err_seen = 1'b1;
    wf = wr_valid && wr_ready;
    if (wf) begin
      writes_seen++;
      last_addr = int'(wr_addr);
      check_output("addr_below_loader", 32'(wr_addr < 12'd4068), 1);
      if (exp_data_q.size() > 0) begin
        check_output("write_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
        check_output("write_data", wr_data, exp_data_q.pop_front());
      end
    end
    bf = rx_valid && rx_ready;
    @(posedge clk);
    if (bf) begin
      void'(byte_q.pop_front());
      bytes_fired++;
      if (bytes_fired == 4) hdr_tick = tick_no;
      if (bytes_fired > 4 && (bytes_fired - 4) % 4 == 0) expect_wv_tick = tick_no + 1;
    end
  endtask

  // Loads header n followed by the words in prog; expected writes are the first n words.
  task automatic run_load(input logic [31:0] n, input int stop_bytes, input int budget);
    byte_q.delete();
    exp_data_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < 4; i++) byte_q.push_back(n[8*i +: 8]);
    for (int i = 0; i < prog.size(); i++) begin
      logic [31:0] w;
      w = prog[i];
      for (int b = 0; b < 4; b++) byte_q.push_back(w[8*b +: 8]);
      if (n <= 32'd4068 && i < int'(n)) begin
        exp_addr_q.push_back(i);
        exp_data_q.push_back(w);
      end
    end
    bytes_fired = 0; writes_seen = 0; done_cnt = 0; err_seen = 1'b0;
    expect_wv_tick = -1; hdr_tick = -1; done_tick = -1; last_addr = -1;
    stalled = 1'b0; prev_done = 1'b0;
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b0; wr_ready = 1'b0;
    @(posedge clk);
    #1;
    check_output("start_err_clear", 32'(err), 0);
    check_output("start_busy", 32'(busy), 1);
    finished = 1'b0;
    for (int c = 0; c < budget; c++) begin
      apply_stimulus();
      if (done_cnt > 0 || err_seen || (stop_bytes > 0 && bytes_fired >= stop_bytes)) begin
        finished = 1'b1;
        break;
      end
    end
    check_output("load_terminated", 32'(finished), 1);
  endtask

  task automatic random_prog(input int count);
    prog.delete();
    for (int i = 0; i < count; i++) prog.push_back($urandom);
  endtask

  initial begin
    int ws;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; wr_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Two-word directed program
    prog = '{32'h0000_0013, 32'h0010_0093};
    run_load(32'd2, 0, 200);
    check_output("basic_done_count", 32'(done_cnt), 1);
    check_output("basic_writes", 32'(writes_seen), 2);
    check_output("basic_pending", 32'(exp_data_q.size()), 0);
    check_output("basic_words_loaded", 32'(words_loaded), 2);
    apply_stimulus();
    check_output("basic_idle_busy", 32'(busy), 0);
    check_output("basic_hold_words", 32'(words_loaded), 2);

    // Empty program finishes right after the header
    prog.delete();
    run_load(32'd0, 0, 100);
    check_output("zero_done_latency", 32'(done_tick - hdr_tick), 1);
    check_output("zero_writes", 32'(writes_seen), 0);
    check_output("zero_words_loaded", 32'(words_loaded), 0);

    // Count one past the last writable word is rejected
    rx_pct = 60;
    random_prog(2);
    run_load(32'd4069, 0, 200);
    check_output("range_err", 32'(err), 1);
    check_output("range_busy", 32'(busy), 0);
    repeat (8) apply_stimulus();
    check_output("range_no_bytes", 32'(bytes_fired), 4);
    check_output("range_no_writes", 32'(writes_seen), 0);
    check_output("range_err_sticky", 32'(err), 1);
    random_prog(3);
    run_load(32'd3, 0, 400);
    check_output("after_err_done", 32'(done_cnt), 1);
    check_output("after_err_writes", 32'(writes_seen), 3);

    // Memory stalls for 20 cycles on the first write
    rx_pct = 100; wr_pct = 100;
    random_prog(3);
    stall_left = 20;
    run_load(32'd3, 0, 400);
    check_output("stall_consumed", 32'(stall_left), 0);
    check_output("stall_writes", 32'(writes_seen), 3);
    check_output("stall_words_loaded", 32'(words_loaded), 3);

    // Random handshakes on a short load
    rx_pct = 50; wr_pct = 60;
    random_prog(5);
    run_load(32'd5, 0, 1000);
    check_output("rand_writes", 32'(writes_seen), 5);
    check_output("rand_words_loaded", 32'(words_loaded), 5);

    // Largest legal program, with one extra word that must not be taken
    rx_pct = 70; wr_pct = 80;
    random_prog(4069);
    run_load(32'd4068, 0, 60000);
    check_output("full_done", 32'(done_cnt), 1);
    check_output("full_writes", 32'(writes_seen), 4068);
    check_output("full_last_addr", 32'(last_addr), 4067);
    check_output("full_words_loaded", 32'(words_loaded), 4068);

    // Reset mid-load, together with start and handshakes
    rx_pct = 100; wr_pct = 100;
    random_prog(2);
    run_load(32'd2, 9, 200);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; rx_valid = 1'b1; wr_ready = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midload_reset");
    @(negedge clk);
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
    byte_q.delete();
    ws = writes_seen;
    repeat (5) apply_stimulus();
    check_output("reset_no_write", 32'(writes_seen), 32'(ws));
    random_prog(2);
    run_load(32'd2, 0, 200);
    check_output("reload_writes", 32'(writes_seen), 2);
    check_output("reload_words_loaded", 32'(words_loaded), 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
